// File: rtl/s_deserializer_if.sv
// Bundles the serial input side and the valid/ready word output of s_deserializer.
interface s_deserializer_if #(
    parameter int unsigned WORD_W = 4
);
    localparam int unsigned CntW = $clog2(WORD_W);

    logic              SIN;
    logic              SIN_VALID;
    logic              SYNC;
    logic              OVR_CLR;
    logic              D_READY;
    logic [WORD_W-1:0] D_OUT;
    logic              D_VALID;
    logic              OVERRUN;
    logic [CntW-1:0]   BIT_CNT;

    modport master (
        output SIN, SIN_VALID, SYNC, OVR_CLR, D_READY,
        input  D_OUT, D_VALID, OVERRUN, BIT_CNT
    );

    modport slave (
        input  SIN, SIN_VALID, SYNC, OVR_CLR, D_READY,
        output D_OUT, D_VALID, OVERRUN, BIT_CNT
    );
endinterface

// File: rtl/s_deserializer.sv
// Framed serial-to-parallel receiver with a single-word valid/ready output and a sticky
// overrun flag for words completed while the previous one is still held.
module s_deserializer #(
    parameter int unsigned WORD_W    = 4,
    parameter int unsigned MSB_FIRST = 0
) (
    input logic              CLK,
    input logic              CLR,
    s_deserializer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WORD_W);

    typedef enum logic [0:0] {StHunt, StRun} state_e;

    state_e            state_q, state_d;
    logic              run_active;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              ovr_q, ovr_d;
    logic [WORD_W-1:0] word;
    logic              word_done;
    logic [CntW-1:0]   pos;
    logic [CntW-1:0]   pos0;

    // FSM: state register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.SYNC) begin
            state_d = StRun;
        end
    end

    // FSM: outputs
    always_comb begin
        run_active = (state_q == StRun);
    end

    // Bit position of the current sample inside the assembled word.
    always_comb begin
        pos0 = (MSB_FIRST != 0) ? CntW'(WORD_W - 1) : '0;
        pos  = (MSB_FIRST != 0) ? CntW'(WORD_W - 1) - cnt_q : cnt_q;
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word      = shift_q;
        word_done = 1'b0;
        if (bus.SYNC) begin
            shift_d = '0;
            cnt_d   = '0;
            if (bus.SIN_VALID) begin
                shift_d[pos0] = bus.SIN;
                cnt_d         = CntW'(1);
            end
        end else if (run_active && bus.SIN_VALID) begin
            word[pos] = bus.SIN;
            if (cnt_q == CntW'(WORD_W - 1)) begin
                word_done = 1'b1;
                shift_d   = '0;
                cnt_d     = '0;
            end else begin
                shift_d = word;
                cnt_d   = cnt_q + CntW'(1);
            end
        end
    end

    // A completed word loads only if the slot is empty or being drained this edge.
    always_comb begin
        dout_d   = dout_q;
        dvalid_d = dvalid_q & ~bus.D_READY;
        ovr_d    = ovr_q & ~bus.OVR_CLR;
        if (word_done) begin
            if (!dvalid_q || bus.D_READY) begin
                dout_d   = word;
                dvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.D_OUT   = dout_q;
    assign bus.D_VALID = dvalid_q;
    assign bus.OVERRUN = ovr_q;
    assign bus.BIT_CNT = cnt_q;
endmodule
